// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures the decoded bundle each cycle, with stall/flush
// handling, a RUN/HALTED drain state machine and a count of valid bundles issued to EX.
module id_ex_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             resume_i,
    input  logic             valid_i,
    input  logic             is_halt_i,
    input  logic             is_branch_i,
    input  logic             is_jal_i,
    input  logic             is_jalr_i,
    input  logic             mem_write_en_i,
    input  logic             mem_read_en_i,
    input  logic             reg_write_en_i,
    input  logic             rd_src_optn_i,
    input  logic             alu_src_optn_i,
    input  logic [1:0]       alu_intent_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  pc_plus4_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    input  logic [4:0]       rd_addr_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7b5_i,
    output logic             valid_o,
    output logic             is_halt_o,
    output logic             is_branch_o,
    output logic             is_jal_o,
    output logic             is_jalr_o,
    output logic             mem_write_en_o,
    output logic             mem_read_en_o,
    output logic             reg_write_en_o,
    output logic             rd_src_optn_o,
    output logic             alu_src_optn_o,
    output logic [1:0]       alu_intent_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus4_o,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [4:0]       rs1_addr_o,
    output logic [4:0]       rs2_addr_o,
    output logic [4:0]       rd_addr_o,
    output logic [2:0]       funct3_o,
    output logic             funct7b5_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] issued_cnt_o
);

    // Handshake: there is no backpressure from EX. valid_i marks a real decode bundle
    // at the sampling edge; valid_o marks a real bundle held for EX this cycle. A
    // bundle with valid_o=0 is a bubble and every other field is then zero.

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic            valid;
        logic            is_halt;
        logic            is_branch;
        logic            is_jal;
        logic            is_jalr;
        logic            mem_write_en;
        logic            mem_read_en;
        logic            reg_write_en;
        logic            rd_src_optn;
        logic            alu_src_optn;
        logic [1:0]      alu_intent;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [2:0]      funct3;
        logic            funct7b5;
    } bundle_t;

    state_t           state_q;
    state_t           state_d;
    bundle_t          in_bundle;
    bundle_t          bundle_q;
    bundle_t          bundle_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_inc;
    logic             capture_valid;

    always_comb begin
        in_bundle              = '0;
        in_bundle.valid        = valid_i;
        in_bundle.is_halt      = is_halt_i;
        in_bundle.is_branch    = is_branch_i;
        in_bundle.is_jal       = is_jal_i;
        in_bundle.is_jalr      = is_jalr_i;
        in_bundle.mem_write_en = mem_write_en_i;
        in_bundle.mem_read_en  = mem_read_en_i;
        in_bundle.reg_write_en = reg_write_en_i;
        in_bundle.rd_src_optn  = rd_src_optn_i;
        in_bundle.alu_src_optn = alu_src_optn_i;
        in_bundle.alu_intent   = alu_intent_i;
        in_bundle.pc           = pc_i;
        in_bundle.pc_plus4     = pc_plus4_i;
        in_bundle.rs1_data     = rs1_data_i;
        in_bundle.rs2_data     = rs2_data_i;
        in_bundle.imm          = imm_i;
        in_bundle.rs1_addr     = rs1_addr_i;
        in_bundle.rs2_addr     = rs2_addr_i;
        in_bundle.rd_addr      = rd_addr_i;
        in_bundle.funct3       = funct3_i;
        in_bundle.funct7b5     = funct7b5_i;
    end

    // A real bundle is taken only in RUN with neither flush nor stall pending.
    assign capture_valid = (state_q == ST_RUN) && !flush_i && !stall_i && valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (capture_valid && is_halt_i) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (resume_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        bundle_d = bundle_q;
        cnt_inc  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_i) begin
                    bundle_d = '0;
                end else if (!stall_i) begin
                    if (valid_i) begin
                        bundle_d = in_bundle;
                        cnt_inc  = 1'b1;
                    end else begin
                        bundle_d = '0;
                    end
                end
            end
            // Draining: bubbles only, whatever the hazard unit or decoder present.
            ST_HALTED: bundle_d = '0;
            default:   bundle_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bundle_q <= '0;
            cnt_q    <= '0;
        end else begin
            bundle_q <= bundle_d;
            if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign valid_o        = bundle_q.valid;
    assign is_halt_o      = bundle_q.is_halt;
    assign is_branch_o    = bundle_q.is_branch;
    assign is_jal_o       = bundle_q.is_jal;
    assign is_jalr_o      = bundle_q.is_jalr;
    assign mem_write_en_o = bundle_q.mem_write_en;
    assign mem_read_en_o  = bundle_q.mem_read_en;
    assign reg_write_en_o = bundle_q.reg_write_en;
    assign rd_src_optn_o  = bundle_q.rd_src_optn;
    assign alu_src_optn_o = bundle_q.alu_src_optn;
    assign alu_intent_o   = bundle_q.alu_intent;
    assign pc_o           = bundle_q.pc;
    assign pc_plus4_o     = bundle_q.pc_plus4;
    assign rs1_data_o     = bundle_q.rs1_data;
    assign rs2_data_o     = bundle_q.rs2_data;
    assign imm_o          = bundle_q.imm;
    assign rs1_addr_o     = bundle_q.rs1_addr;
    assign rs2_addr_o     = bundle_q.rs2_addr;
    assign rd_addr_o      = bundle_q.rd_addr;
    assign funct3_o       = bundle_q.funct3;
    assign funct7b5_o     = bundle_q.funct7b5;
    assign halted_o       = (state_q == ST_HALTED);
    assign issued_cnt_o   = cnt_q;

endmodule
